fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the RISC-V core: owns the fetch PC, drives the synchronous-read instruction
//   memory, and presents the IF/ID instruction, PC and valid bit to decode (and so to imm_gen).
//   Handles stall (hold decode contents), redirect (branch/jump target, squash wrong path)
//   and reset. A hold register keeps decode stable during stalls without using the memory enable.
// PARAMETERS
//   N         32             datapath / PC width
//   RESET_PC  32'h4000_0000  first fetch address after reset
//   IMEM_AW   14             instruction memory word-address width
//   NOP_INSTR 32'h0000_0013  addi x0,x0,0, presented whenever valid=0
// PORTS
//   clk          in   1        core clock, all state on rising edge
//   rst          in   1        synchronous, active-high reset
//   stall        in   1        hazard unit: hold IF and IF/ID this cycle
//   redirect     in   1        EX resolved taken branch/jump: refetch from redirect_pc
//   redirect_pc  in   N        target; bits [1:0] forced to 0
//   imem_addr    out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2], combinational from fetch_pc
//   imem_en      out  1        constant 1 (memory is free-running)
//   imem_dout    in   N        read data, 1-cycle latency after imem_addr
//   instr        out  N        IF/ID instruction to decode / imm_gen
//   pc_out       out  N        PC of instr (id_pc)
//   pc_plus4     out  N        id_pc + 4, mod 2^N
//   valid        out  1        instr is a real, non-squashed instruction
// BEHAVIOUR
//   State: fetch_pc, id_pc, id_valid, hold_instr, hold_vld (plus id_src if the macro is on).
//   instr = !id_valid ? NOP_INSTR : hold_vld ? hold_instr : imem_dout   (combinational)
//   Reset (rst=1, priority over all): fetch_pc<=RESET_PC, id_pc<=0, id_valid<=0,
//     hold_vld<=0, hold_instr<=0. While in reset and 1 cycle after: valid=0, instr=NOP, pc_out=0.
//   Priority per cycle: rst > redirect > stall > advance.
//   Advance (!stall,!redirect): id_pc<=fetch_pc, id_valid<=1, hold_vld<=0, fetch_pc<=fetch_pc+4.
//   Stall (stall,!redirect): fetch_pc, id_pc, id_valid held. If !hold_vld: hold_instr<=imem_dout,
//     hold_vld<=1. If hold_vld already set, hold_instr unchanged. Multi-cycle stalls are legal.
//     imem_addr stays at fetch_pc, so after release imem_dout = mem[fetch_pc].
//   Redirect (overrides stall): fetch_pc<={redirect_pc[N-1:2],2'b00}, id_valid<=0, hold_vld<=0.
//     The next cycle shows a NOP bubble; instr from redirect_pc is valid 2 cycles after redirect.
//   Latency: address in fetch_pc at cycle t -> instr at t+1 with valid=1, unless stalled/squashed.
//   Wrap: fetch_pc+4 and pc_plus4 wrap modulo 2^N with no flag. imem_addr truncates high PC bits.
//   Back-to-back redirects: each one resets the fetch. Only the last target's instr becomes valid.
//   rst asserted mid-stall or mid-redirect: the reset values above win in that cycle.
// CONFIGURATION
//   FETCH_BIOS_SEL_EN defined: adds ports bios_addr (out, IMEM_AW) = imem_addr and
//     bios_dout (in, N). Source select src = (fetch_pc[31:28]==4'h4) is registered as id_src on
//     advance/redirect. Data mux is id_src ? bios_dout : imem_dout and feeds both instr
//     and hold capture.
//   Undefined: bios ports are absent. instr always sources imem_dout.
// TESTING
//   1 reset 3 cycles, release -> fetch addrs 0x4000_0000,_0004,_0008; valid=1 from 2nd cycle
//     after release; pc_out follows 1 cycle behind.
//   2 stall 3 cycles while instr=0x0050_0093 @pc 0x40000008 -> instr/pc_out constant all 3 cycles;
//     after release pc_out=0x4000000C with the word from mem[3].
//   3 redirect to 0x1000_0002 -> next cycle valid=0, instr=0x13. The cycle after:
//     pc_out=0x1000_0000, valid=1.
//   4 redirect and stall in the same cycle -> redirect wins: bubble, then target instr. The hold
//     register is cleared.
//   5 redirect_pc=0xFFFF_FFFC, run 2 cycles -> pc_out 0xFFFFFFFC then 0x0, pc_plus4=0x0 at first.
//   6 assert rst during a stall with hold_vld=1 -> next cycle valid=0, fetch_pc=RESET_PC,
//     hold_vld=0.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the RISC-V core. It owns the fetch PC, drives
//   the synchronous-read instruction memory and presents the IF/ID
//   instruction, its PC and a valid bit to decode (and from there to imm_gen).
//   Stall holds the decode contents. Redirect reloads the fetch PC from a
//   resolved branch/jump target and squashes the wrong-path instruction.
//   Synchronous reset restarts fetch at RESET_PC.
//
//   The memory enable is tied high, so the memory reads every cycle. A hold
//   register captures the decode instruction on the first stall cycle. This
//   keeps decode stable while the memory output moves on to the next word.
//
// Optional feature (macro FETCH_BIOS_SEL_EN):
//   Adds a second instruction source (BIOS ROM). Each fetch whose PC has
//   top nibble 4'h4 is tagged as a BIOS fetch. The tag travels with the
//   instruction into IF/ID as id_src and selects between bios_dout and
//   imem_dout. When the macro is undefined, the bios ports do not exist and
//   the instruction always comes from imem_dout.
//
// Parameters:
//   N          datapath / PC width
//   RESET_PC   first fetch address after reset
//   IMEM_AW    instruction memory word-address width
//   NOP_INSTR  instruction presented whenever valid = 0
//
// Ports:
//   clk          in   core clock, rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hold IF and IF/ID this cycle
//   redirect     in   refetch from redirect_pc (wins over stall)
//   redirect_pc  in   redirect target; bits [1:0] are ignored
//   imem_addr    out  word address = fetch_pc[IMEM_AW+1:2]
//   imem_en      out  constant 1
//   imem_dout    in   memory read data, one cycle after imem_addr
//   bios_addr    out  (FETCH_BIOS_SEL_EN only) same as imem_addr
//   bios_dout    in   (FETCH_BIOS_SEL_EN only) BIOS read data
//   instr        out  IF/ID instruction
//   pc_out       out  PC of instr
//   pc_plus4     out  pc_out + 4, wraps modulo 2^N
//   valid        out  instr is real and not squashed
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_PC  = 32'h4000_0000,
  parameter int             IMEM_AW   = 14,
  parameter logic [N-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [N-1:0]       redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [N-1:0]       imem_dout,
`ifdef FETCH_BIOS_SEL_EN
  output logic [IMEM_AW-1:0] bios_addr,
  input  logic [N-1:0]       bios_dout,
`endif
  output logic [N-1:0]       instr,
  output logic [N-1:0]       pc_out,
  output logic [N-1:0]       pc_plus4,
  output logic               valid
);

  localparam logic [N-1:0] PC_STEP    = N'(4);
  localparam logic [N-1:0] ALIGN_MASK = ~(N'(3));

  logic [N-1:0] fetch_pc;
  logic [N-1:0] id_pc;
  logic         id_valid;
  logic [N-1:0] hold_instr;
  logic         hold_vld;

  logic [N-1:0] redirect_target;
  logic [N-1:0] mem_data;

  // Targets are forced onto a word boundary. Masking the whole vector keeps
  // every bit of redirect_pc in use.
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // The memory address comes straight from fetch_pc. During a stall it stays
  // on the next PC, so after release the memory already holds that word.
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign imem_en   = 1'b1;

`ifdef FETCH_BIOS_SEL_EN
  logic id_src;
  logic src;

  assign bios_addr = imem_addr;
  assign src       = (fetch_pc[N-1:N-4] == 4'h4);
  assign mem_data  = id_src ? bios_dout : imem_dout;
`else
  assign mem_data  = imem_dout;
`endif

  // Sequential state. Priority: rst > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      id_pc      <= '0;
      id_valid   <= 1'b0;
      hold_vld   <= 1'b0;
      hold_instr <= '0;
`ifdef FETCH_BIOS_SEL_EN
      id_src     <= 1'b0;
`endif
    end else if (redirect) begin
      // Squash the instruction in IF/ID. The next cycle is a bubble, and the
      // target's word arrives one cycle after that.
      fetch_pc   <= redirect_target;
      id_valid   <= 1'b0;
      hold_vld   <= 1'b0;
`ifdef FETCH_BIOS_SEL_EN
      id_src     <= src;
`endif
    end else if (stall) begin
      // Only the first stall cycle captures the word. Later cycles would see
      // the memory output for the following PC.
      if (!hold_vld) begin
        hold_instr <= mem_data;
        hold_vld   <= 1'b1;
      end
    end else begin
      id_pc    <= fetch_pc;
      id_valid <= 1'b1;
      hold_vld <= 1'b0;
      fetch_pc <= fetch_pc + PC_STEP;
`ifdef FETCH_BIOS_SEL_EN
      id_src   <= src;
`endif
    end
  end

  always_comb begin
    instr = mem_data;
    if (!id_valid) begin
      instr = NOP_INSTR;
    end else if (hold_vld) begin
      instr = hold_instr;
    end
  end

  assign pc_out   = id_pc;
  assign pc_plus4 = id_pc + PC_STEP;
  assign valid    = id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        valid;
`ifdef FETCH_BIOS_SEL_EN
  logic [13:0] bios_addr;
  logic [31:0] bios_dout;
`endif

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_dout   (imem_dout),
`ifdef FETCH_BIOS_SEL_EN
    .bios_addr   (bios_addr),
    .bios_dout   (bios_dout),
`endif
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: four hand-placed words, everything else 0xA000_0000 | addr.
  function automatic logic [31:0] memword(input logic [13:0] a);
    case (a)
      14'd0:   memword = 32'h0010_0093;
      14'd1:   memword = 32'h0030_0093;
      14'd2:   memword = 32'h0050_0093;
      14'd3:   memword = 32'h0070_0093;
      default: memword = 32'hA000_0000 | {18'd0, a};
    endcase
  endfunction

  always @(posedge clk) if (imem_en) imem_dout <= memword(imem_addr);
`ifdef FETCH_BIOS_SEL_EN
  always @(posedge clk) bios_dout <= memword(bios_addr);
`endif

  typedef struct {
    int          step;
    logic        valid;
    logic [31:0] instr;
    logic        chk_pc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [13:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   step_no = 0;

  task automatic chk(input string name, input int stp, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, stp, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid", e.step, {31'd0, valid}, {31'd0, e.valid});
        chk("instr", e.step, instr, e.instr);
        chk("imem_addr", e.step, {18'd0, imem_addr}, {18'd0, e.addr});
        chk("imem_en", e.step, {31'd0, imem_en}, 32'd1);
        if (e.chk_pc) begin
          chk("pc_out", e.step, pc_out, e.pc);
          chk("pc_plus4", e.step, pc_plus4, e.pc4);
        end
      end
    end
  end

  // One cycle: apply inputs for this cycle and queue the outputs expected in it.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input logic ev, input logic [31:0] ei,
                      input logic cp, input logic [31:0] epc, input logic [31:0] ep4,
                      input logic [13:0] ea);
    exp_t e;
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    step_no++;
    e.step = step_no; e.valid = ev; e.instr = ei; e.chk_pc = cp;
    e.pc = epc; e.pc4 = ep4; e.addr = ea;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk);
    //   rst stall redir rpc            valid instr          chkpc pc             pc+4           addr
    // reset held 3 cycles, then one more bubble cycle after release
    step(1, 0, 0, 32'h0,          0, NOP,           1, 32'h0,          32'h4,          14'h0);
    step(1, 0, 0, 32'h0,          0, NOP,           1, 32'h0,          32'h4,          14'h0);
    step(1, 0, 0, 32'h0,          0, NOP,           1, 32'h0,          32'h4,          14'h0);
    step(0, 0, 0, 32'h0,          0, NOP,           1, 32'h0,          32'h4,          14'h0);
    step(0, 0, 0, 32'h0,          1, 32'h0010_0093, 1, 32'h4000_0000, 32'h4000_0004, 14'h1);
    step(0, 0, 0, 32'h0,          1, 32'h0030_0093, 1, 32'h4000_0004, 32'h4000_0008, 14'h2);
    // 3-cycle stall on 0x40000008
    step(0, 1, 0, 32'h0,          1, 32'h0050_0093, 1, 32'h4000_0008, 32'h4000_000C, 14'h3);
    step(0, 1, 0, 32'h0,          1, 32'h0050_0093, 1, 32'h4000_0008, 32'h4000_000C, 14'h3);
    step(0, 1, 0, 32'h0,          1, 32'h0050_0093, 1, 32'h4000_0008, 32'h4000_000C, 14'h3);
    step(0, 0, 0, 32'h0,          1, 32'h0050_0093, 1, 32'h4000_0008, 32'h4000_000C, 14'h3);
    // release: mem[3]; redirect to misaligned 0x1000_0002
    step(0, 0, 1, 32'h1000_0002,  1, 32'h0070_0093, 1, 32'h4000_000C, 32'h4000_0010, 14'h4);
    step(0, 0, 0, 32'h0,          0, NOP,           0, 32'h0,          32'h0,          14'h0);
    // stall to fill hold, then redirect+stall together
    step(0, 1, 0, 32'h0,          1, 32'h0010_0093, 1, 32'h1000_0000, 32'h1000_0004, 14'h1);
    step(0, 1, 1, 32'h2000_0010,  1, 32'h0010_0093, 1, 32'h1000_0000, 32'h1000_0004, 14'h1);
    step(0, 0, 0, 32'h0,          0, NOP,           0, 32'h0,          32'h0,          14'h4);
    // target word, hold cleared; then redirect to top of address space
    step(0, 0, 1, 32'hFFFF_FFFC,  1, 32'hA000_0004, 1, 32'h2000_0010, 32'h2000_0014, 14'h5);
    step(0, 0, 0, 32'h0,          0, NOP,           0, 32'h0,          32'h0,          14'h3FFF);
    step(0, 0, 0, 32'h0,          1, 32'hA000_3FFF, 1, 32'hFFFF_FFFC, 32'h0000_0000, 14'h0);
    // back-to-back redirects: only 0x204 survives
    step(0, 0, 1, 32'h0000_0100,  1, 32'h0010_0093, 1, 32'h0000_0000, 32'h0000_0004, 14'h1);
    step(0, 0, 1, 32'h0000_0204,  0, NOP,           0, 32'h0,          32'h0,          14'h40);
    step(0, 0, 0, 32'h0,          0, NOP,           0, 32'h0,          32'h0,          14'h81);
    // stall to fill hold, then reset mid-stall
    step(0, 1, 0, 32'h0,          1, 32'hA000_0081, 1, 32'h0000_0204, 32'h0000_0208, 14'h82);
    step(1, 1, 0, 32'h0,          1, 32'hA000_0081, 1, 32'h0000_0204, 32'h0000_0208, 14'h82);
    step(0, 0, 0, 32'h0,          0, NOP,           1, 32'h0,          32'h4,          14'h0);
    step(0, 0, 0, 32'h0,          1, 32'h0010_0093, 1, 32'h4000_0000, 32'h4000_0004, 14'h1);
    @(negedge clk);
    #1;
    chk("queue_drained", step_no, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
